// File: rtl/uart_rx_packetizer.sv
// uart_rx_packetizer
//   Turns the byte stream from a UART receiver into framed command packets:
//   SYNC, CMD, LEN, LEN payload bytes and, when the checksum is built in, a
//   modulo-256 checksum over CMD, LEN and the payload.
//   Completed packets are held on a valid/ready interface. Malformed or stalled
//   frames raise a one-cycle error pulse.
//
//   Build option: define UART_PKT_CHECKSUM_EN to add the trailing checksum byte
//   and its check (error code 2). With it undefined, a frame ends after its
//   last payload byte, or after LEN when LEN is zero.
//
// Ports
//   clk_100MHz    sole clock
//   reset_n       asynchronous active-low reset
//   in_valid      one-cycle strobe, byte received
//   in_data       received byte
//   pkt_valid     packet available, held until pkt_ready
//   pkt_ready     consumer accepts the packet
//   pkt_cmd       command byte
//   pkt_len       payload length, 0..MAX_PAYLOAD
//   pkt_data      payload, first byte in [7:0], unused bytes zero
//   pkt_err       one-cycle error pulse
//   pkt_err_code  last error: 1 bad length, 2 checksum, 3 timeout
//   drop_count    saturating count of bytes dropped while a packet is held
module uart_rx_packetizer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_PAYLOAD    = 4,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter int         TO_BITS        = 20
) (
    input  logic                     clk_100MHz,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     pkt_valid,
    input  logic                     pkt_ready,
    output logic [7:0]               pkt_cmd,
    output logic [7:0]               pkt_len,
    output logic [8*MAX_PAYLOAD-1:0] pkt_data,
    output logic                     pkt_err,
    output logic [1:0]               pkt_err_code,
    output logic [7:0]               drop_count
);
    // state     | meaning
    // S_HUNT    | discard bytes until SYNC_BYTE
    // S_CMD     | expect the command byte
    // S_LEN     | expect the payload length
    // S_PAYLOAD | collect pkt_len payload bytes
    // S_CSUM    | expect the checksum byte (checksum builds only)
    // S_HOLD    | packet presented, waiting for pkt_ready
    typedef enum logic [2:0] {
        S_HUNT,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
`ifdef UART_PKT_CHECKSUM_EN
        S_CSUM,
`endif
        S_HOLD
    } state_t;

    // The idle counter is loaded with TIMEOUT_CYCLES-1 on every accepted
    // byte. Reaching zero with no byte in the same cycle marks expiry, so
    // expiry falls TIMEOUT_CYCLES cycles after the last byte.
    localparam logic [TO_BITS-1:0] TO_LOAD = TO_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         MAX_LEN = 8'(MAX_PAYLOAD);

    state_t             state;
    state_t             state_nxt;
    logic               err_set;
    logic [1:0]         err_code_nxt;
    logic               in_frame;
    logic [7:0]         idx;
    logic [TO_BITS-1:0] to_cnt;
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0]         sum;
`endif

    assign in_frame = (state == S_CMD) || (state == S_LEN) || (state == S_PAYLOAD)
`ifdef UART_PKT_CHECKSUM_EN
                      || (state == S_CSUM)
`endif
                      ;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) state <= S_HUNT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        err_set      = 1'b0;
        err_code_nxt = pkt_err_code;
        case (state)
            S_HUNT: if (in_valid && in_data == SYNC_BYTE) state_nxt = S_CMD;
            S_CMD:  if (in_valid) state_nxt = S_LEN;
            S_LEN: begin
                if (in_valid) begin
                    if (in_data > MAX_LEN) begin
                        err_set      = 1'b1;
                        err_code_nxt = 2'd1;
                        state_nxt    = S_HUNT;
                    end else if (in_data == 8'd0) begin
`ifdef UART_PKT_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_HOLD;
`endif
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (in_valid && idx == pkt_len - 8'd1) begin
`ifdef UART_PKT_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_HOLD;
`endif
                end
            end
`ifdef UART_PKT_CHECKSUM_EN
            S_CSUM: begin
                if (in_valid) begin
                    if (in_data == sum) begin
                        state_nxt = S_HOLD;
                    end else begin
                        err_set      = 1'b1;
                        err_code_nxt = 2'd2;
                        state_nxt    = S_HUNT;
                    end
                end
            end
`endif
            S_HOLD:  if (pkt_ready) state_nxt = S_HUNT;
            default: state_nxt = S_HUNT;
        endcase
        // A byte in the expiry cycle is processed above and wins.
        if (in_frame && !in_valid && to_cnt == '0) begin
            err_set      = 1'b1;
            err_code_nxt = 2'd3;
            state_nxt    = S_HUNT;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            pkt_valid    <= 1'b0;
            pkt_err      <= 1'b0;
            pkt_err_code <= 2'd0;
            pkt_cmd      <= 8'd0;
            pkt_len      <= 8'd0;
            pkt_data     <= '0;
            drop_count   <= 8'd0;
            idx          <= 8'd0;
            to_cnt       <= '0;
        end else begin
            pkt_valid    <= (state_nxt == S_HOLD);
            pkt_err      <= err_set;
            pkt_err_code <= err_code_nxt;

            if (in_valid || !in_frame) to_cnt <= TO_LOAD;
            else if (to_cnt != '0)     to_cnt <= to_cnt - 1'b1;

            if (state == S_HOLD && in_valid && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;

            case (state)
                S_HUNT: begin
                    if (state_nxt == S_CMD) begin
                        pkt_data <= '0;
                        idx      <= 8'd0;
                    end
                end
                S_CMD: if (in_valid) pkt_cmd <= in_data;
                S_LEN: if (in_valid && in_data <= MAX_LEN) pkt_len <= in_data;
                S_PAYLOAD: begin
                    if (in_valid) begin
                        for (int i = 0; i < MAX_PAYLOAD; i++)
                            if (idx == 8'(i)) pkt_data[i*8 +: 8] <= in_data;
                        idx <= idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UART_PKT_CHECKSUM_EN
    // Held at zero while hunting, which clears it on entry to S_CMD.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n)
            sum <= 8'd0;
        else if (state == S_HUNT)
            sum <= 8'd0;
        else if (in_valid && (state == S_CMD || state == S_LEN || state == S_PAYLOAD))
            sum <= sum + in_data;
    end
`endif

endmodule

// File: tb/tb_uart_rx_packetizer.sv
module tb_uart_rx_packetizer;
    localparam int MAXP = 4;
    localparam int TOC  = 50;

    logic              clk_100MHz = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [7:0]        pkt_cmd;
    logic [7:0]        pkt_len;
    logic [8*MAXP-1:0] pkt_data;
    logic              pkt_err;
    logic [1:0]        pkt_err_code;
    logic [7:0]        drop_count;

    uart_rx_packetizer #(
        .SYNC_BYTE(8'hA5), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TOC), .TO_BITS(8)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_cmd(pkt_cmd), .pkt_len(pkt_len), .pkt_data(pkt_data),
        .pkt_err(pkt_err), .pkt_err_code(pkt_err_code), .drop_count(drop_count)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        logic [0:7][7:0] bytes;
        int              n;
        logic            valid;
        logic [7:0]      cmd;
        logic [7:0]      len;
        logic [31:0]     data;
        logic            err;
        logic [1:0]      code;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic [0:7][7:0] b, input int n, input logic v,
                       input logic [7:0] c, input logic [7:0] l, input logic [31:0] d,
                       input logic e, input logic [1:0] code);
        vec_t t;
        t.bytes = b; t.n = n; t.valid = v; t.cmd = c; t.len = l;
        t.data = d; t.err = e; t.code = code;
        vecs.push_back(t);
    endtask

    // Call at a negedge; bytes go out on consecutive cycles and the task
    // returns at the negedge right after the last byte was sampled.
    task automatic send(input logic [0:7][7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = b[i];
            @(negedge clk_100MHz);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:7][7:0] f1;
        int              n1;
        vec_t            v;

`ifdef UART_PKT_CHECKSUM_EN
        f1 = {8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33, 16'h0}; n1 = 6;
        add(f1, 6, 1, 8'h01, 8'd2, 32'h0000_2010, 0, 2'd0);
        add({8'hA5, 8'h07, 8'h00, 8'h07, 32'h0}, 4, 1, 8'h07, 8'd0, 32'h0, 0, 2'd0);
        add({8'hA5, 8'h01, 8'h05, 40'h0}, 3, 0, 8'h00, 8'd0, 32'h0, 1, 2'd1);
        add({8'hA5, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6B, 8'h0}, 7, 1, 8'h02, 8'd3, 32'h0033_2211, 0, 2'd1);
        add({8'hA5, 8'h01, 8'h01, 8'hAA, 8'h00, 24'h0}, 5, 0, 8'h00, 8'd0, 32'h0, 1, 2'd2);
        add({8'hA5, 8'h09, 8'h04, 8'hA5, 8'h01, 8'h02, 8'h03, 8'hB8}, 8, 1, 8'h09, 8'd4, 32'h0302_01A5, 0, 2'd2);
        add({8'hA5, 8'h03, 8'h01, 8'h5A, 8'h5E, 24'h0}, 5, 1, 8'h03, 8'd1, 32'h0000_005A, 0, 2'd2);
        add({8'h00, 8'h33, 8'hA5, 8'h04, 8'h00, 8'h04, 16'h0}, 6, 1, 8'h04, 8'd0, 32'h0, 0, 2'd2);
`else
        f1 = {8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 24'h0}; n1 = 5;
        add(f1, 5, 1, 8'h01, 8'd2, 32'h0000_2010, 0, 2'd0);
        add({8'hA5, 8'h07, 8'h00, 40'h0}, 3, 1, 8'h07, 8'd0, 32'h0, 0, 2'd0);
        add({8'hA5, 8'h01, 8'h05, 40'h0}, 3, 0, 8'h00, 8'd0, 32'h0, 1, 2'd1);
        add({8'hA5, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 16'h0}, 6, 1, 8'h02, 8'd3, 32'h0033_2211, 0, 2'd1);
        add({8'hA5, 8'h01, 8'h01, 8'hAA, 32'h0}, 4, 1, 8'h01, 8'd1, 32'h0000_00AA, 0, 2'd1);
        add({8'hA5, 8'h09, 8'h04, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h0}, 7, 1, 8'h09, 8'd4, 32'h0302_01A5, 0, 2'd1);
        add({8'hA5, 8'h03, 8'h01, 8'h5A, 32'h0}, 4, 1, 8'h03, 8'd1, 32'h0000_005A, 0, 2'd1);
        add({8'h00, 8'h33, 8'hA5, 8'h04, 8'h00, 24'h0}, 5, 1, 8'h04, 8'd0, 32'h0, 0, 2'd1);
`endif

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        pkt_ready = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        chk("rst_valid", pkt_valid, 0);
        chk("rst_err", pkt_err, 0);
        chk("rst_code", pkt_err_code, 0);
        chk("rst_cmd", pkt_cmd, 0);
        chk("rst_len", pkt_len, 0);
        chk("rst_data", pkt_data, 0);
        chk("rst_drop", drop_count, 0);
        reset_n = 1'b1;
        @(negedge clk_100MHz);

        // Table: frames sent back to back, ready held high.
        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            send(v.bytes, v.n);
            chk($sformatf("v%0d_valid", k), pkt_valid, v.valid);
            chk($sformatf("v%0d_err", k), pkt_err, v.err);
            chk($sformatf("v%0d_code", k), pkt_err_code, v.code);
            if (v.valid) begin
                chk($sformatf("v%0d_cmd", k), pkt_cmd, v.cmd);
                chk($sformatf("v%0d_len", k), pkt_len, v.len);
                chk($sformatf("v%0d_data", k), pkt_data, v.data);
            end
            @(negedge clk_100MHz);
            chk($sformatf("v%0d_valid_after", k), pkt_valid, 0);
            chk($sformatf("v%0d_err_after", k), pkt_err, 0);
        end

        // Timeout: error pulse 51 cycles after the last byte.
        send({8'hA5, 8'h01, 48'h0}, 2);
        repeat (TOC - 1) @(negedge clk_100MHz);
        chk("to_err_before", pkt_err, 0);
        @(negedge clk_100MHz);
        chk("to_err", pkt_err, 1);
        chk("to_code", pkt_err_code, 3);
        @(negedge clk_100MHz);
        chk("to_err_pulse", pkt_err, 0);
        send(f1, n1);
        chk("to_next_valid", pkt_valid, 1);
        chk("to_next_data", pkt_data, 32'h0000_2010);
        @(negedge clk_100MHz);

        // A byte landing exactly on the expiry cycle is processed instead.
        send({8'hA5, 8'h01, 48'h0}, 2);
        repeat (TOC - 1) @(negedge clk_100MHz);
        send({8'h00, 56'h0}, 1);
        chk("exp_byte_err", pkt_err, 0);
`ifdef UART_PKT_CHECKSUM_EN
        chk("exp_byte_valid_early", pkt_valid, 0);
        send({8'h01, 56'h0}, 1);
`endif
        chk("exp_byte_valid", pkt_valid, 1);
        chk("exp_byte_cmd", pkt_cmd, 8'h01);
        chk("exp_byte_len", pkt_len, 8'd0);
        chk("exp_byte_err2", pkt_err, 0);
        @(negedge clk_100MHz);

        // Hold: stalled consumer, dropped bytes, release with a byte in flight.
        pkt_ready = 1'b0;
        send(f1, n1);
        send({8'hA5, 8'h12, 8'h34, 40'h0}, 3);
        chk("hold_valid", pkt_valid, 1);
        chk("hold_cmd", pkt_cmd, 8'h01);
        chk("hold_len", pkt_len, 8'd2);
        chk("hold_data", pkt_data, 32'h0000_2010);
        chk("hold_drop", drop_count, 3);
        pkt_ready = 1'b1;
        send({8'hA5, 56'h0}, 1);
        chk("rel_valid", pkt_valid, 0);
        chk("rel_drop", drop_count, 4);
        send({8'h01, 8'h00, 8'h01, 40'h0}, 3);
        chk("rel_not_parsed", pkt_valid, 0);

        // Saturation of the drop counter.
        pkt_ready = 1'b0;
        send(f1, n1);
        for (int i = 0; i < 260; i++) send({8'h5A, 56'h0}, 1);
        chk("sat_drop", drop_count, 8'd255);
        chk("sat_valid", pkt_valid, 1);
        pkt_ready = 1'b1;
        @(negedge clk_100MHz);
        chk("sat_release", pkt_valid, 0);

        // Reset in the middle of a frame clears everything at once.
        send({8'hA5, 8'h01, 8'h02, 8'h10, 32'h0}, 4);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", pkt_valid, 0);
        chk("mid_rst_cmd", pkt_cmd, 0);
        chk("mid_rst_len", pkt_len, 0);
        chk("mid_rst_data", pkt_data, 0);
        chk("mid_rst_code", pkt_err_code, 0);
        chk("mid_rst_drop", drop_count, 0);
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        @(negedge clk_100MHz);
        send({8'h20, 8'h33, 48'h0}, 2);
        chk("mid_rst_discard", pkt_valid, 0);
        chk("mid_rst_no_err", pkt_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_packetizer.md
# uart_rx_packetizer

Assembles framed command packets from the byte stream produced by the UART receiver. It sits between the receiver's `data_ready`/`data_out` outputs and the application logic, which consumes whole packets. It hunts for a sync byte, then collects the command, length, payload and an optional checksum. It presents each completed packet on a valid/ready interface and flags malformed or stalled frames.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `MAX_PAYLOAD`, 4, maximum payload bytes per frame (1..16).
- `TIMEOUT_CYCLES`, 1_000_000, idle cycles allowed between bytes inside a frame (10 ms at 100 MHz).
- `TO_BITS`, 20, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- `clk_100MHz` input 1: sole clock.
- `reset_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: one-cycle pulse, byte received (receiver `data_ready`).
- `in_data` input 8: received byte (receiver `data_out`).
- `pkt_valid` output 1: packet available; held until accepted.
- `pkt_ready` input 1: consumer accepts packet.
- `pkt_cmd` output 8: command byte.
- `pkt_len` output 8: payload length, 0..MAX_PAYLOAD.
- `pkt_data` output 8*MAX_PAYLOAD: payload; first byte in [7:0]; unused bytes zero.
- `pkt_err` output 1: one-cycle error pulse.
- `pkt_err_code` output 2: code of the last error: 1 = bad length, 2 = checksum, 3 = timeout. Holds until the next error.
- `drop_count` output 8: saturating count of bytes dropped while a packet is pending.

## Operation
- States:
  - HUNT → CMD on `in_valid && in_data==SYNC_BYTE`. Any other byte is ignored silently.
  - CMD → LEN on a byte; latch `pkt_cmd`.
  - LEN, on a byte:
    - If the value > MAX_PAYLOAD: error code 1, go to HUNT.
    - If the value is 0: go to CSUM, or to HOLD when the checksum is compiled out.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: store each byte at index `idx` (0-based), then increment `idx`. After byte `len-1`, go to CSUM (or HOLD).
  - CSUM: compare the byte with the running sum. On a match go to HOLD; otherwise error code 2 and go to HUNT.
  - HOLD: `pkt_valid`=1. On `pkt_ready`, go to HUNT.
- Running sum is 8-bit modulo-256 over CMD, LEN and all payload bytes. It is cleared on entry to CMD.
- `pkt_data` is cleared on entry to CMD, so stale bytes never leak into a shorter packet.
- Any byte arriving in HOLD is dropped and increments `drop_count`, which saturates at 255. It is not parsed, even if it equals SYNC_BYTE.
- SYNC_BYTE inside CMD/LEN/PAYLOAD/CSUM is ordinary data; there is no resync.
- Timeout:
  - The counter runs only in CMD, LEN, PAYLOAD and CSUM, and resets on every accepted byte.
  - On reaching TIMEOUT_CYCLES: error code 3, go to HUNT.
- Reset: state HUNT; `pkt_valid`=0, `pkt_err`=0, `pkt_err_code`=0, `pkt_cmd`=0, `pkt_len`=0, `pkt_data`=0, `drop_count`=0; counters cleared. A reset mid-frame discards the partial frame.

## Timing
- All outputs are registered.
- Final frame byte (`in_valid` at cycle N) → `pkt_valid` high at N+1.
- Error detected on the byte at cycle N (or timeout expiry at N) → `pkt_err` high at N+1 for exactly one cycle; `pkt_err_code` updated the same cycle.
- `pkt_valid && pkt_ready` at cycle M → `pkt_valid` low at M+1. The earliest the next frame's SYNC byte is accepted is M+1.
- `pkt_cmd`, `pkt_len` and `pkt_data` are stable while `pkt_valid`=1.
- `in_valid` in the same cycle as timeout expiry: the byte wins, is processed, and the timeout is suppressed.
- `in_valid` in the same cycle as `pkt_ready` in HOLD: the byte is dropped and counted.
- Back-to-back `in_valid` on consecutive cycles must be accepted without loss.

## Configuration
- `UART_PKT_CHECKSUM_EN` defined: the CSUM state exists and the frame is SYNC, CMD, LEN, payload, CHECKSUM; error code 2 is possible.
- `UART_PKT_CHECKSUM_EN` undefined: no CSUM state. The frame ends after the last payload byte, or after LEN when LEN=0. The sum logic is removed and error code 2 never occurs.

## Test plan
- Bytes A5 01 02 10 20 33, `pkt_ready`=1 (checksum enabled):
  - `pkt_valid` is high for 1 cycle, one cycle after 33.
  - `pkt_cmd`=01, `pkt_len`=2, `pkt_data`=32'h0000_2010, no `pkt_err`.
- Bytes A5 07 00 07:
  - Zero-length packet; `pkt_cmd`=07, `pkt_len`=0, `pkt_data`=0.
- Bytes A5 01 05 with MAX_PAYLOAD=4:
  - `pkt_err` pulse with code 1, state returns to HUNT.
  - A following valid frame is then received correctly.
- Bytes A5 01 01 AA 00:
  - `pkt_err` pulse with code 2; no `pkt_valid`.
- Bytes A5 01, then idle for TIMEOUT_CYCLES (bench with TIMEOUT_CYCLES=50):
  - `pkt_err` code 3 at cycle 51 after byte 01.
  - A byte arriving exactly at expiry produces no error.
- Valid frame with `pkt_ready`=0, then 3 further bytes:
  - `pkt_valid` stays high and the data is unchanged; `drop_count`=3.
  - After `pkt_ready`, `pkt_valid` drops.
  - Assert `reset_n` mid-frame: all outputs return to 0 immediately.
